// File: rtl/sdram_arb_pkg.sv
// Shared types and default parameters for the two-port SDRAM arbiter.
// Contents:
//   grant_e            arbiter grant state (no grant, port 0, port 1)
//   *_DEF localparams  default geometry for the x16 SDRAM behind sdram_wire
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        GntNone = 2'd0,
        Gnt0    = 2'd1,
        Gnt1    = 2'd2
    } grant_e;

    localparam int unsigned ADDR_W_DEF     = 25;  // 13 row + 10 col + 2 bank
    localparam int unsigned DATA_W_DEF     = 16;
    localparam int unsigned BE_W_DEF       = 2;
    localparam int unsigned MAX_PEND_DEF   = 8;
    localparam int unsigned BURST_HOLD_DEF = 4;

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// Tag FIFO for outstanding reads: one bit per entry naming the issuing port.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset (flushes the FIFO)
//   i_push, i_tag    enqueue the tag of an accepted read
//   i_pop            dequeue on read data return (ignored while empty)
//   o_head           tag of the oldest outstanding read
//   o_full, o_empty  occupancy flags derived from the entry count
module sdram_arb_tag_fifo
    import sdram_arb_pkg::*;
#(
    parameter int unsigned DEPTH = MAX_PEND_DEF  // power of 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_push,
    input  logic i_tag,
    input  logic i_pop,
    output logic o_head,
    output logic o_full,
    output logic o_empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] r_mem;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop & ~w_empty;
    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_tag;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/sdram_arbiter_2p.sv
// Two-port round-robin arbiter in front of the SDRAM controller Avalon-MM slave.
// Port 0 is the Nios II data master, port 1 a second requester (frame/DMA).
// Ports:
//   clk_clk, reset_reset_n           clock, asynchronous active-low reset
//   m0_* / m1_*                      requester Avalon-MM slave side
//   s_*                              master side toward the SDRAM controller
//   err_orphan                       sticky: read data returned with no read pending
module sdram_arbiter_2p
    import sdram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned BE_W       = BE_W_DEF,
    parameter int unsigned MAX_PEND   = MAX_PEND_DEF,
    parameter int unsigned BURST_HOLD = BURST_HOLD_DEF
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic [BE_W-1:0]   m0_byteenable,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [BE_W-1:0]   m1_byteenable,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DATA_W-1:0] s_writedata,
    output logic [BE_W-1:0]   s_byteenable,
    input  logic              s_waitrequest,
    input  logic [DATA_W-1:0] s_readdata,
    input  logic              s_readdatavalid,

    output logic              err_orphan
);

    localparam int unsigned HOLD_W = $clog2(BURST_HOLD + 1);

    grant_e            r_grant;
    grant_e            w_grant_nxt;
    logic              r_last;        // last port served; 1 so port 0 wins first tie
    logic              w_last_nxt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic [HOLD_W-1:0] w_hold_inc;
    logic              r_err_orphan;

    logic w_req0;
    logic w_req1;
    logic w_fifo_full;
    logic w_fifo_empty;
    logic w_head;
    logic w_pop;
    logic w_full_stall;
    logic w_sel_read;
    logic w_sel_write;
    logic w_sel_wait;
    logic w_accept;
    logic w_push;
    logic w_other_req;

    assign w_req0     = m0_read | m0_write;
    assign w_req1     = m1_read | m1_write;
    assign w_pop      = s_readdatavalid & ~w_fifo_empty;
    // A full FIFO frees a slot in the same cycle the head returns, so the
    // stalled read may be accepted together with the pop.
    assign w_full_stall = w_fifo_full & ~s_readdatavalid;
    assign w_hold_inc = r_hold_cnt + HOLD_W'(1);

    // Command mux and per-port stall.
    always_comb begin
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        s_byteenable   = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        w_sel_read     = 1'b0;
        w_sel_write    = 1'b0;
        w_sel_wait     = 1'b1;
        unique case (r_grant)
            Gnt0: begin
                w_sel_read     = m0_read;
                w_sel_write    = m0_write;
                s_address      = m0_address;
                s_writedata    = m0_writedata;
                s_byteenable   = m0_byteenable;
                s_read         = m0_read & ~w_full_stall;
                s_write        = m0_write;
                w_sel_wait     = s_waitrequest | (m0_read & w_full_stall);
                m0_waitrequest = w_sel_wait;
            end
            Gnt1: begin
                w_sel_read     = m1_read;
                w_sel_write    = m1_write;
                s_address      = m1_address;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                s_read         = m1_read & ~w_full_stall;
                s_write        = m1_write;
                w_sel_wait     = s_waitrequest | (m1_read & w_full_stall);
                m1_waitrequest = w_sel_wait;
            end
            default: ;
        endcase
    end

    assign w_accept    = (w_sel_read | w_sel_write) & ~w_sel_wait;
    assign w_push      = w_accept & w_sel_read;
    assign w_other_req = (r_grant == Gnt0) ? w_req1 : w_req0;

    // Grant next-state, hold counter and round-robin pointer.
    always_comb begin
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        w_hold_nxt  = r_hold_cnt;
        unique case (r_grant)
            GntNone: begin
                w_hold_nxt = '0;
                if (w_req0 && w_req1) begin
                    w_grant_nxt = r_last ? Gnt0 : Gnt1;
                end else if (w_req0) begin
                    w_grant_nxt = Gnt0;
                end else if (w_req1) begin
                    w_grant_nxt = Gnt1;
                end
            end
            Gnt0, Gnt1: begin
                if (w_sel_read || w_sel_write) begin
                    // A stalled command keeps the grant until it is accepted.
                    if (w_accept) begin
                        if (w_hold_inc == HOLD_W'(BURST_HOLD) && w_other_req) begin
                            w_grant_nxt = (r_grant == Gnt0) ? Gnt1 : Gnt0;
                            w_last_nxt  = (r_grant == Gnt1);
                            w_hold_nxt  = '0;
                        end else if (w_hold_inc != HOLD_W'(BURST_HOLD)) begin
                            // Saturates one short of the limit so the next
                            // accept yields as soon as the other port asks.
                            w_hold_nxt = w_hold_inc;
                        end
                    end
                end else begin
                    if (w_other_req) begin
                        w_grant_nxt = (r_grant == Gnt0) ? Gnt1 : Gnt0;
                    end else begin
                        w_grant_nxt = GntNone;
                    end
                    w_last_nxt = (r_grant == Gnt1);
                    w_hold_nxt = '0;
                end
            end
            default: begin
                w_grant_nxt = GntNone;
                w_hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_grant      <= GntNone;
            r_last       <= 1'b1;
            r_hold_cnt   <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            r_grant      <= w_grant_nxt;
            r_last       <= w_last_nxt;
            r_hold_cnt   <= w_hold_nxt;
            r_err_orphan <= r_err_orphan | (s_readdatavalid & w_fifo_empty);
        end
    end

    sdram_arb_tag_fifo #(
        .DEPTH (MAX_PEND)
    ) u_tag_fifo (
        .i_clk   (clk_clk),
        .i_rst_n (reset_reset_n),
        .i_push  (w_push),
        .i_tag   (r_grant == Gnt1),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Read data is broadcast; only the valid is steered by the head tag.
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = w_pop & ~w_head;
    assign m1_readdatavalid = w_pop & w_head;
    assign err_orphan       = r_err_orphan;

endmodule

// File: tb/tb_sdram_arbiter_2p.sv
// Directed bench for sdram_arbiter_2p; the bench plays the SDRAM controller.
// Inputs change on the falling edge, outputs are sampled 1 ns later.
module tb_sdram_arbiter_2p;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic [24:0] m0_address, m1_address, s_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [15:0] m0_writedata, m1_writedata, s_writedata;
    logic [1:0]  m0_byteenable, m1_byteenable, s_byteenable;
    logic        m0_waitrequest, m1_waitrequest;
    logic [15:0] m0_readdata, m1_readdata, s_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic        s_read, s_write, s_waitrequest, s_readdatavalid;
    logic        err_orphan;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk_clk = ~clk_clk;

    sdram_arbiter_2p u_dut (
        .clk_clk          (clk_clk),
        .reset_reset_n    (reset_reset_n),
        .m0_address       (m0_address),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_byteenable    (m0_byteenable),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_byteenable    (m1_byteenable),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .s_address        (s_address),
        .s_read           (s_read),
        .s_write          (s_write),
        .s_writedata      (s_writedata),
        .s_byteenable     (s_byteenable),
        .s_waitrequest    (s_waitrequest),
        .s_readdata       (s_readdata),
        .s_readdatavalid  (s_readdatavalid),
        .err_orphan       (err_orphan)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = 16'h1111; m0_byteenable = 2'b11;
        m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = 16'h2222; m1_byteenable = 2'b11;
        s_waitrequest = 0; s_readdata = '0; s_readdatavalid = 0;
    endtask

    // Leaves the bench on a falling edge with reset released and grant NONE.
    task automatic do_reset();
        clear_inputs();
        reset_reset_n = 1'b0;
        @(negedge clk_clk);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
    endtask

    function automatic logic [1:0] accepts();
        return {m1_write & ~m1_waitrequest | m1_read & ~m1_waitrequest,
                m0_write & ~m0_waitrequest | m0_read & ~m0_waitrequest};
    endfunction

    logic [1:0]  exp_rr [13] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2,
                                 2'd1, 2'd1, 2'd1, 2'd1};
    logic [1:0]  exp_rt [3]  = '{2'b01, 2'b10, 2'b01};
    logic [15:0] dat_rt [3]  = '{16'hB0, 16'hB1, 16'hB2};

    initial begin
        // Reset state.
        clear_inputs();
        #1;
        check_val("rst s_read", s_read, 0);
        check_val("rst s_write", s_write, 0);
        check_val("rst m0_wait", m0_waitrequest, 1);
        check_val("rst m1_wait", m1_waitrequest, 1);
        check_val("rst rdv", {m1_readdatavalid, m0_readdatavalid}, 0);
        check_val("rst err", err_orphan, 0);

        // Port 0 alone: three reads, controller latency 3.
        do_reset();
        m0_read = 1; m0_address = 25'h10; #1;
        check_val("t1 c0 m0_wait", m0_waitrequest, 1);
        check_val("t1 c0 s_read", s_read, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_clk);
            m0_address = 25'h10 + 25'(i); #1;
            check_val($sformatf("t1 acc%0d m0_wait", i), m0_waitrequest, 0);
            check_val($sformatf("t1 acc%0d s_read", i), s_read, 1);
            check_val($sformatf("t1 acc%0d s_addr", i), 32'(s_address), 32'h10 + i);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_clk);
            m0_read = 0; s_readdatavalid = 1; s_readdata = 16'hA0 + 16'(i); #1;
            check_val($sformatf("t1 ret%0d valid", i), {m1_readdatavalid, m0_readdatavalid}, 2'b01);
            check_val($sformatf("t1 ret%0d data", i), m0_readdata, 16'hA0 + i);
        end
        @(negedge clk_clk);
        s_readdatavalid = 0; #1;
        check_val("t1 err", err_orphan, 0);

        // Both ports write continuously: 4 x p0, 4 x p1, 4 x p0, no idle at switch.
        do_reset();
        m0_write = 1; m1_write = 1;
        for (int c = 0; c < 13; c++) begin
            #1;
            check_val($sformatf("t2 accept c%0d", c), accepts(), exp_rr[c]);
            @(negedge clk_clk);
        end

        // Interleaved reads p0, p1, p0 returned in issue order.
        do_reset();
        m0_read = 1; m0_address = 25'h20; #1;
        check_val("t3 c0 m0_wait", m0_waitrequest, 1);
        @(negedge clk_clk); #1;
        check_val("t3 c1 accept", accepts(), 2'b01);
        @(negedge clk_clk);
        m0_read = 0; m1_read = 1; m1_address = 25'h21; #1;
        check_val("t3 c2 m1_wait", m1_waitrequest, 1);
        @(negedge clk_clk); #1;
        check_val("t3 c3 accept", accepts(), 2'b10);
        check_val("t3 c3 s_addr", 32'(s_address), 32'h21);
        @(negedge clk_clk);
        m1_read = 0; m0_read = 1; m0_address = 25'h22; #1;
        check_val("t3 c4 m0_wait", m0_waitrequest, 1);
        @(negedge clk_clk); #1;
        check_val("t3 c5 accept", accepts(), 2'b01);
        check_val("t3 c5 s_addr", 32'(s_address), 32'h22);
        @(negedge clk_clk);
        m0_read = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_clk);
            s_readdatavalid = 1; s_readdata = dat_rt[i]; #1;
            check_val($sformatf("t3 ret%0d route", i), {m1_readdatavalid, m0_readdatavalid}, exp_rt[i]);
            check_val($sformatf("t3 ret%0d data", i),
                      exp_rt[i][0] ? m0_readdata : m1_readdata, dat_rt[i]);
        end
        @(negedge clk_clk);
        s_readdatavalid = 0;

        // Eight reads outstanding; ninth (p1) stalls until the first return.
        do_reset();
        m0_read = 1;
        @(negedge clk_clk);
        for (int i = 0; i < 8; i++) begin
            #1;
            check_val($sformatf("t4 fill%0d accept", i), accepts(), 2'b01);
            @(negedge clk_clk);
        end
        m0_read = 0; m1_read = 1; #1;
        check_val("t4 c9 m1_wait", m1_waitrequest, 1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_clk); #1;
            check_val($sformatf("t4 full%0d m1_wait", i), m1_waitrequest, 1);
            check_val($sformatf("t4 full%0d s_read", i), s_read, 0);
        end
        @(negedge clk_clk);
        s_readdatavalid = 1; s_readdata = 16'hC0; #1;
        check_val("t4 pop m1_wait", m1_waitrequest, 0);
        check_val("t4 pop s_read", s_read, 1);
        check_val("t4 pop m0_rdv", m0_readdatavalid, 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_clk);
            m1_read = 0; #1;
            check_val($sformatf("t4 drain%0d route", i), {m1_readdatavalid, m0_readdatavalid},
                      (i == 7) ? 2'b10 : 2'b01);
        end
        @(negedge clk_clk);
        s_readdatavalid = 0; #1;
        check_val("t4 err", err_orphan, 0);

        // Controller stalls a p0 write for 5 cycles while p1 waits.
        do_reset();
        m0_write = 1; m1_write = 1; s_waitrequest = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_clk); #1;
            check_val($sformatf("t5 stall%0d m0_wait", i), m0_waitrequest, 1);
            check_val($sformatf("t5 stall%0d m1_wait", i), m1_waitrequest, 1);
            check_val($sformatf("t5 stall%0d s_write", i), s_write, 1);
        end
        @(negedge clk_clk);
        s_waitrequest = 0; #1;
        check_val("t5 release accept", accepts(), 2'b01);
        @(negedge clk_clk);
        m0_write = 0; #1;
        check_val("t5 drop m1_wait", m1_waitrequest, 1);
        @(negedge clk_clk); #1;
        check_val("t5 p1 accept", accepts(), 2'b10);

        // Reset with three reads in flight, then a stray return.
        do_reset();
        m0_read = 1;
        for (int i = 0; i < 4; i++) @(negedge clk_clk);
        reset_reset_n = 0; #1;
        check_val("t6 rst s_read", s_read, 0);
        check_val("t6 rst m0_wait", m0_waitrequest, 1);
        check_val("t6 rst m1_wait", m1_waitrequest, 1);
        check_val("t6 rst rdv", {m1_readdatavalid, m0_readdatavalid}, 0);
        m0_read = 0;
        @(negedge clk_clk);
        reset_reset_n = 1;
        @(negedge clk_clk);
        s_readdatavalid = 1; s_readdata = 16'hDD; #1;
        check_val("t6 stray rdv", {m1_readdatavalid, m0_readdatavalid}, 0);
        check_val("t6 err before edge", err_orphan, 0);
        @(negedge clk_clk);
        s_readdatavalid = 0; #1;
        check_val("t6 err set", err_orphan, 1);
        @(negedge clk_clk); #1;
        check_val("t6 err sticky", err_orphan, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
